// File: rtl/scpad_pkg.sv
// ---------------------------------------------------------------------------
// scpad_pkg
// Shared definitions for the scratchpad tile walker and the swizzle stage.
//   NUM_COLS       : number of scratchpad banks (power of two)
//   ROW_IDX_WIDTH  : width of a scratchpad row address / row extent
//   COL_IDX_WIDTH  : width of a column index / column extent
//   TAG_WIDTH      : width of the request id carried on every beat
//   walker_state_t : walker FSM encoding
//   tile_req_t     : one tile-access request as seen by the swizzle side
// ---------------------------------------------------------------------------
package scpad_pkg;

    localparam int NUM_COLS      = 32;
    localparam int ROW_IDX_WIDTH = 10;
    localparam int COL_IDX_WIDTH = $clog2(NUM_COLS);
    localparam int TAG_WIDTH     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } walker_state_t;

    typedef struct packed {
        logic [ROW_IDX_WIDTH-1:0] spad_addr;
        logic [ROW_IDX_WIDTH-1:0] num_rows;
        logic [COL_IDX_WIDTH-1:0] num_cols;
        logic                     row_or_col;
        logic [TAG_WIDTH-1:0]     tag;
    } tile_req_t;

endpackage

// File: rtl/scpad_tile_walker.sv
// ---------------------------------------------------------------------------
// scpad_tile_walker
// Accepts one tile-access request and emits one beat per tile row
// (row-major) or per tile column (column-major) towards the swizzle stage.
// Every out_* signal comes straight from a flop.
//
// Handshake rule (both sides): a transfer happens on a rising CLK edge where
// valid && ready are both high. A producer holds valid and its payload
// stable until the transfer; out_valid never depends on out_ready.
//
// Ports:
//   CLK, RST         : clock, synchronous active-high reset
//   req_*            : request channel (base row, extents minus one,
//                      orientation 1=row-major/0=column-major, tag)
//   out_*            : beat channel (swizzle-stage inputs plus out_last)
//   busy             : walker is in WALK (also the FSM state observation)
//   err_clamp        : one-cycle pulse when a column-major num_rows was clamped
// ---------------------------------------------------------------------------
module scpad_tile_walker
    import scpad_pkg::*;
#(
    parameter int NUM_COLS      = scpad_pkg::NUM_COLS,
    parameter int ROW_IDX_WIDTH = scpad_pkg::ROW_IDX_WIDTH,
    parameter int COL_IDX_WIDTH = $clog2(NUM_COLS),
    parameter int TAG_WIDTH     = scpad_pkg::TAG_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ROW_IDX_WIDTH-1:0] req_spad_addr,
    input  logic [ROW_IDX_WIDTH-1:0] req_num_rows,
    input  logic [COL_IDX_WIDTH-1:0] req_num_cols,
    input  logic                     req_row_or_col,
    input  logic [TAG_WIDTH-1:0]     req_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROW_IDX_WIDTH-1:0] out_spad_addr,
    output logic [ROW_IDX_WIDTH-1:0] out_row_id,
    output logic [COL_IDX_WIDTH-1:0] out_col_id,
    output logic [ROW_IDX_WIDTH-1:0] out_num_rows,
    output logic [COL_IDX_WIDTH-1:0] out_num_cols,
    output logic                     out_row_or_col,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic                     out_last,
    output logic                     busy,
    output logic                     err_clamp
);

    localparam logic [ROW_IDX_WIDTH-1:0] MAX_COL_ROWS = ROW_IDX_WIDTH'(NUM_COLS - 1);

    walker_state_t            state, state_n;
    logic [ROW_IDX_WIDTH-1:0] cnt, cnt_n;
    logic                     out_valid_n, out_last_n, err_clamp_n;
    logic [ROW_IDX_WIDTH-1:0] out_spad_addr_n, out_row_id_n, out_num_rows_n;
    logic [COL_IDX_WIDTH-1:0] out_col_id_n, out_num_cols_n;
    logic                     out_row_or_col_n;
    logic [TAG_WIDTH-1:0]     out_tag_n;

    logic                     fire, last_fire, accept, clamp;
    logic [ROW_IDX_WIDTH-1:0] cnt_inc, req_extent, cur_extent;

    always_comb begin
        fire       = out_valid && out_ready;
        last_fire  = fire && out_last;
        req_ready  = (state == IDLE) || last_fire;
        accept     = req_valid && req_ready;
        clamp      = !req_row_or_col && (req_num_rows > MAX_COL_ROWS);
        cnt_inc    = cnt + 1'b1;
        // Extent of the walk: rows for row-major, columns for column-major.
        req_extent = req_row_or_col ? req_num_rows : ROW_IDX_WIDTH'(req_num_cols);
        cur_extent = out_row_or_col ? out_num_rows : ROW_IDX_WIDTH'(out_num_cols);
    end

    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        out_valid_n      = out_valid;
        out_last_n       = out_last;
        out_spad_addr_n  = out_spad_addr;
        out_row_id_n     = out_row_id;
        out_col_id_n     = out_col_id;
        out_num_rows_n   = out_num_rows;
        out_num_cols_n   = out_num_cols;
        out_row_or_col_n = out_row_or_col;
        out_tag_n        = out_tag;
        err_clamp_n      = 1'b0;

        if (accept) begin
            // Covers both a fresh start from IDLE and a back-to-back tile
            // taken on the final beat of the previous one.
            state_n          = WALK;
            cnt_n            = '0;
            out_valid_n      = 1'b1;
            out_last_n       = (req_extent == '0);
            out_spad_addr_n  = req_spad_addr;
            out_row_id_n     = '0;
            out_col_id_n     = '0;
            out_num_rows_n   = clamp ? MAX_COL_ROWS : req_num_rows;
            out_num_cols_n   = req_num_cols;
            out_row_or_col_n = req_row_or_col;
            out_tag_n        = req_tag;
            err_clamp_n      = clamp;
        end else if (last_fire) begin
            state_n     = IDLE;
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
        end else if (fire) begin
            cnt_n        = cnt_inc;
            out_row_id_n = out_row_or_col ? cnt_inc : '0;
            out_col_id_n = out_row_or_col ? '0 : cnt_inc[COL_IDX_WIDTH-1:0];
            out_last_n   = (cnt_inc == cur_extent);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            cnt            <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_spad_addr  <= '0;
            out_row_id     <= '0;
            out_col_id     <= '0;
            out_num_rows   <= '0;
            out_num_cols   <= '0;
            out_row_or_col <= 1'b0;
            out_tag        <= '0;
            err_clamp      <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            out_valid      <= out_valid_n;
            out_last       <= out_last_n;
            out_spad_addr  <= out_spad_addr_n;
            out_row_id     <= out_row_id_n;
            out_col_id     <= out_col_id_n;
            out_num_rows   <= out_num_rows_n;
            out_num_cols   <= out_num_cols_n;
            out_row_or_col <= out_row_or_col_n;
            out_tag        <= out_tag_n;
            err_clamp      <= err_clamp_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_scpad_tile_walker.sv
// ---------------------------------------------------------------------------
// tb_scpad_tile_walker
// Directed bench for scpad_tile_walker (NUM_COLS=32, ROW_IDX_WIDTH=10).
// Inputs change 1ns after the rising edge; outputs are checked in that
// settled window, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_scpad_tile_walker;

    logic       CLK = 1'b0;
    logic       RST;
    logic       req_valid;
    logic       req_ready;
    logic [9:0] req_spad_addr;
    logic [9:0] req_num_rows;
    logic [4:0] req_num_cols;
    logic       req_row_or_col;
    logic [3:0] req_tag;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_spad_addr;
    logic [9:0] out_row_id;
    logic [4:0] out_col_id;
    logic [9:0] out_num_rows;
    logic [4:0] out_num_cols;
    logic       out_row_or_col;
    logic [3:0] out_tag;
    logic       out_last;
    logic       busy;
    logic       err_clamp;

    int tests  = 0;
    int failed = 0;

    scpad_tile_walker dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_spad_addr(req_spad_addr), .req_num_rows(req_num_rows),
        .req_num_cols(req_num_cols), .req_row_or_col(req_row_or_col),
        .req_tag(req_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_spad_addr(out_spad_addr), .out_row_id(out_row_id),
        .out_col_id(out_col_id), .out_num_rows(out_num_rows),
        .out_num_cols(out_num_cols), .out_row_or_col(out_row_or_col),
        .out_tag(out_tag), .out_last(out_last),
        .busy(busy), .err_clamp(err_clamp)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic set_req(input logic [9:0] addr, input logic [9:0] nr,
                           input logic [4:0] nc, input logic rc, input logic [3:0] tag);
        req_spad_addr  = addr;
        req_num_rows   = nr;
        req_num_cols   = nc;
        req_row_or_col = rc;
        req_tag        = tag;
        req_valid      = 1'b1;
    endtask

    initial begin
        RST = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
        req_spad_addr = '0; req_num_rows = '0; req_num_cols = '0;
        req_row_or_col = 1'b0; req_tag = '0;

        // Reset state
        step(); step();
        RST = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_err_clamp", err_clamp, 0);
        chk("rst_last", out_last, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_addr", out_spad_addr, 0);

        // Row-major basic: 4 beats, row_id 0..3
        set_req(10'd100, 10'd3, 5'd7, 1'b1, 4'd1);
        chk("rm_req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("rm_addr", out_spad_addr, 100);
        chk("rm_num_rows", out_num_rows, 3);
        chk("rm_num_cols", out_num_cols, 7);
        chk("rm_rc", out_row_or_col, 1);
        chk("rm_tag", out_tag, 1);
        chk("rm_busy_ready", req_ready, 0);
        for (int k = 0; k < 4; k++) begin
            chk("rm_valid", out_valid, 1);
            chk("rm_row_id", out_row_id, k);
            chk("rm_col_id", out_col_id, 0);
            chk("rm_last", out_last, (k == 3) ? 1 : 0);
            step();
        end
        chk("rm_done_valid", out_valid, 0);
        chk("rm_done_busy", busy, 0);

        // Column-major with clamp: num_rows 40 -> 31, col_id 0..2
        set_req(10'd0, 10'd40, 5'd2, 1'b0, 4'd2);
        step();
        req_valid = 1'b0;
        chk("cm_err_clamp", err_clamp, 1);
        chk("cm_num_rows", out_num_rows, 31);
        chk("cm_rc", out_row_or_col, 0);
        for (int k = 0; k < 3; k++) begin
            chk("cm_valid", out_valid, 1);
            chk("cm_col_id", out_col_id, k);
            chk("cm_row_id", out_row_id, 0);
            chk("cm_last", out_last, (k == 2) ? 1 : 0);
            if (k > 0) chk("cm_clamp_pulse", err_clamp, 0);
            step();
        end
        chk("cm_done_valid", out_valid, 0);

        // Column-major without clamp: num_rows 31 kept, extent from num_cols 0
        set_req(10'd8, 10'd31, 5'd0, 1'b0, 4'd9);
        step();
        req_valid = 1'b0;
        chk("cm31_err_clamp", err_clamp, 0);
        chk("cm31_num_rows", out_num_rows, 31);
        chk("cm31_last", out_last, 1);
        step();

        // Backpressure: beat 1 held for 4 cycles
        set_req(10'd50, 10'd2, 5'd0, 1'b1, 4'd3);
        step();
        req_valid = 1'b0;
        chk("bp_row0", out_row_id, 0);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_row", out_row_id, 1);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_last", out_last, 0);
            chk("bp_hold_tag", out_tag, 3);
            step();
        end
        out_ready = 1'b1;
        chk("bp_row1", out_row_id, 1);
        step();
        chk("bp_row2", out_row_id, 2);
        chk("bp_last", out_last, 1);
        step();
        chk("bp_done", out_valid, 0);

        // Back-to-back tiles with no idle cycle
        set_req(10'd200, 10'd1, 5'd0, 1'b1, 4'd4);
        step();
        req_valid = 1'b0;
        chk("b2b_a_row0", out_row_id, 0);
        step();
        chk("b2b_a_last", out_last, 1);
        set_req(10'd300, 10'd1, 5'd0, 1'b1, 4'd5);
        chk("b2b_req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("b2b_b_valid", out_valid, 1);
        chk("b2b_b_tag", out_tag, 5);
        chk("b2b_b_row0", out_row_id, 0);
        chk("b2b_b_addr", out_spad_addr, 300);
        chk("b2b_b_busy", busy, 1);
        step();
        chk("b2b_b_row1", out_row_id, 1);
        chk("b2b_b_last", out_last, 1);
        step();
        chk("b2b_done", out_valid, 0);

        // Single-beat tile
        set_req(10'd7, 10'd0, 5'd3, 1'b1, 4'd6);
        step();
        req_valid = 1'b0;
        chk("sb_valid", out_valid, 1);
        chk("sb_last", out_last, 1);
        chk("sb_req_ready", req_ready, 1);
        step();
        chk("sb_done_valid", out_valid, 0);
        chk("sb_done_busy", busy, 0);

        // Reset mid-walk at beat 2 of 8
        set_req(10'd400, 10'd7, 5'd0, 1'b1, 4'd7);
        step();
        req_valid = 1'b0;
        step(); step();
        chk("rmw_row2", out_row_id, 2);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rmw_valid", out_valid, 0);
        chk("rmw_busy", busy, 0);
        chk("rmw_req_ready", req_ready, 1);
        step();
        chk("rmw_no_beat", out_valid, 0);
        set_req(10'd500, 10'd1, 5'd0, 1'b1, 4'd8);
        step();
        req_valid = 1'b0;
        chk("rmw_new_row0", out_row_id, 0);
        chk("rmw_new_tag", out_tag, 8);
        chk("rmw_new_valid", out_valid, 1);
        step(); step();
        chk("rmw_new_done", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/scpad_tile_walker.md
Name: scpad_tile_walker

Overview:
- Upstream sequencer for the scratchpad swizzle stage.
- Accepts one tile-access request: base row, extent, orientation, tag.
- Emits one beat per tile row (row-major) or per tile column (column-major), each carrying the swizzle-stage inputs (spad_addr, row_id, col_id, num_rows, num_cols, row_or_col).
- Valid/ready on both sides; output is fully registered so the swizzle combinational path starts at flops.

Parameters:
- NUM_COLS, 32, number of banks; power of two.
- ROW_IDX_WIDTH, 10, width of scratchpad row address and num_rows.
- COL_IDX_WIDTH, $clog2(NUM_COLS), width of col_id and num_cols.
- TAG_WIDTH, 4, request tag passed through to every beat.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_spad_addr  in  ROW_IDX_WIDTH  tile base row.
- req_num_rows  in  ROW_IDX_WIDTH  tile rows minus one.
- req_num_cols  in  COL_IDX_WIDTH  tile cols minus one.
- req_row_or_col  in  1  1 = row-major, 0 = column-major.
- req_tag  in  TAG_WIDTH  request id.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_spad_addr  out  ROW_IDX_WIDTH  latched base row.
- out_row_id  out  ROW_IDX_WIDTH  current row (row-major), else 0.
- out_col_id  out  COL_IDX_WIDTH  current column (column-major), else 0.
- out_num_rows  out  ROW_IDX_WIDTH  latched, after clamp.
- out_num_cols  out  COL_IDX_WIDTH  latched.
- out_row_or_col  out  1  latched orientation.
- out_tag  out  TAG_WIDTH  latched tag.
- out_last  out  1  final beat of the tile.
- busy  out  1  state != IDLE.
- err_clamp  out  1  one-cycle pulse: column-major num_rows exceeded NUM_COLS-1 and was clamped.

Behaviour:
- States:
  - IDLE: no request in progress.
  - WALK: beats being issued.
- Reset (RST high at a clock edge), taking priority over everything else:
  - State goes to IDLE; all out_* are 0; err_clamp = 0; busy = 0.
  - Reset mid-tile drops the tile; no further beats are issued.
- req_ready = (state == IDLE) || (out_valid && out_ready && out_last).
  - This gives back-to-back tiles with no bubble.
- On accept:
  - Latch all request fields.
  - Beat counter = 0.
  - state = WALK; out_valid = 1 on the next cycle with beat 0.
- Row-major beats: row_id = k for k = 0..num_rows; col_id = 0; total beats = num_rows + 1.
- Column-major beats: col_id = k for k = 0..num_cols; row_id = 0; total beats = num_cols + 1.
- Column-major clamp: if req_num_rows > NUM_COLS-1:
  - Latch num_rows = NUM_COLS-1.
  - err_clamp pulses high on the cycle after accept.
  - The walk proceeds normally.
- Clamp never applies in row-major.
- out_last = 1 when the counter equals the latched extent (num_rows or num_cols).
- Advance rule:
  - The counter and outputs update only when out_valid && out_ready.
  - While out_ready is 0, every out_* holds stable (no bubbles, no drops).
- On out_last handshake:
  - With no new request: state = IDLE, out_valid = 0 next cycle.
  - With a simultaneous request: beat 0 of the new tile is presented next cycle.
- Latency: accept to first out_valid is 1 cycle. Sustained throughput is 1 beat/cycle with out_ready held high.
- Single-beat tile (extent 0): one beat with out_last = 1.
- Arithmetic:
  - Counter width is ROW_IDX_WIDTH.
  - spad_addr + row_id wrap-around is the swizzle stage's concern; the walker does not add and does not check overflow.
- out_valid never depends combinationally on out_ready.
- Request inputs are sampled only at accept; changes while busy are ignored.

Decomposition:
- scpad_pkg holds:
  - NUM_COLS, ROW_IDX_WIDTH, COL_IDX_WIDTH.
  - walker_state_t enum {IDLE, WALK}.
  - packed struct tile_req_t {spad_addr, num_rows, num_cols, row_or_col, tag}, shared with the swizzle interface.
- No sub-module; a single always_ff with next-state always_comb.
- Optional: a scpad_tile_walker_if interface mirroring the swizzle interface style.

Test Plan:
- Row-major basic: addr=100, num_rows=3, num_cols=7, rc=1, out_ready=1 -> 4 beats, row_id 0,1,2,3 on consecutive cycles; out_last only on beat 3; busy drops the cycle after.
- Column-major clamp: addr=0, num_rows=40, num_cols=2, rc=0, NUM_COLS=32 -> err_clamp pulses once; out_num_rows=31; 3 beats with col_id 0,1,2.
- Backpressure: row-major num_rows=2; out_ready low for 3 cycles on beat 1 -> beat 1 held stable for all 4 cycles; no skipped or duplicated row_id.
- Back-to-back: second request (tag=5) valid during first tile's last beat -> req_ready=1 that cycle; next cycle shows tag=5, row_id=0; zero idle cycles between tiles.
- Single-beat tile: num_rows=0, rc=1 -> exactly one beat with out_last=1; req_ready reasserted in the same cycle it is accepted.
- Reset mid-walk: RST high at beat 2 of 8 -> next cycle out_valid=0, busy=0, req_ready=1; a new request afterwards starts at row_id 0.
